// File: rtl/jtag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_pkg : TAP state encodings, DR selector and opcode constants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jtag_pkg;

  // Standard 1149.1 state codes, so tap_state is meaningful on a debugger.
  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BSR  = 2'd0,
    DR_SCAN = 2'd1,
    DR_ID   = 2'd2,
    DR_BYP  = 2'd3
  } dr_sel_e;

  localparam logic [1:0] c_OP_EXTEST  = 2'd0;
  localparam logic [1:0] c_OP_SAMPLE  = 2'd1;
  localparam logic [1:0] c_OP_INTSCAN = 2'd2;
  localparam logic [1:0] c_OP_IDCODE  = 2'd3;

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_tap_fsm : 16-state IEEE 1149.1 TAP controller                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e r_state;
  tap_state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (TRST) r_state <= TAP_TLR;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TAP_TLR:      w_state_nxt = TMS ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      w_state_nxt = TMS ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   w_state_nxt = TMS ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   w_state_nxt = TMS ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: w_state_nxt = TMS ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: w_state_nxt = TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_state_nxt = TMS ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: w_state_nxt = TMS ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   w_state_nxt = TMS ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   w_state_nxt = TMS ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   w_state_nxt = TMS ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: w_state_nxt = TMS ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: w_state_nxt = TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_state_nxt = TMS ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: w_state_nxt = TMS ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   w_state_nxt = TMS ? TAP_SEL_DR   : TAP_RTI;
      default:      w_state_nxt = TAP_TLR;
    endcase
  end

  assign state = r_state;

endmodule : jtag_tap_fsm
`default_nettype wire

// File: rtl/jtag_tap_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtag_tap_param : parameterised TAP with BSR, internal scan, IDCODE   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 3,
  parameter int          BSR_LEN    = 150,
  parameter int          SCAN_LEN   = 43,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                clk,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  input  logic [BSR_LEN-1:0]  bsr_pin_in,
  output logic [BSR_LEN-1:0]  bsr_pin_out,
  output logic                bsr_oe,
  input  logic [SCAN_LEN-1:0] scan_cap,
  output logic [SCAN_LEN-1:0] scan_upd,
  output logic [3:0]          tap_state,
  output logic [IR_W-1:0]     ir_q
);

  localparam logic [IR_W-1:0] c_IR_EXTEST  = IR_W'(c_OP_EXTEST);
  localparam logic [IR_W-1:0] c_IR_SAMPLE  = IR_W'(c_OP_SAMPLE);
  localparam logic [IR_W-1:0] c_IR_INTSCAN = IR_W'(c_OP_INTSCAN);
  localparam logic [IR_W-1:0] c_IR_IDCODE  = IR_W'(c_OP_IDCODE);
  localparam logic [IR_W-1:0] c_IR_CAPTURE = IR_W'(2'b01);

  tap_state_e w_state;

  logic [IR_W-1:0]     r_ir_sh;
  logic [IR_W-1:0]     r_ir_q;
  logic                r_bsr_oe;
  logic [BSR_LEN-1:0]  r_bsr_sh;
  logic [BSR_LEN-1:0]  r_bsr_upd;
  logic [SCAN_LEN-1:0] r_scan_sh;
  logic [SCAN_LEN-1:0] r_scan_upd;
  logic [31:0]         r_id_sh;
  logic                r_byp;

  dr_sel_e w_dr_sel;
  logic    w_tdo;

  jtag_tap_fsm u_fsm (
    .clk   (clk),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (w_state)
  );

  // Unassigned opcodes, including all-ones, fall through to bypass.
  always_comb begin
    w_dr_sel = DR_BYP;
    if (r_ir_q == c_IR_EXTEST || r_ir_q == c_IR_SAMPLE) w_dr_sel = DR_BSR;
    else if (r_ir_q == c_IR_INTSCAN)                    w_dr_sel = DR_SCAN;
    else if (r_ir_q == c_IR_IDCODE)                     w_dr_sel = DR_ID;
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      r_ir_sh    <= '0;
      r_ir_q     <= c_IR_IDCODE;
      r_bsr_oe   <= 1'b0;
      r_bsr_sh   <= '0;
      r_bsr_upd  <= '0;
      r_scan_sh  <= '0;
      r_scan_upd <= '0;
      r_id_sh    <= '0;
      r_byp      <= 1'b0;
    end else begin
      case (w_state)
        TAP_TLR: begin
          r_ir_q   <= c_IR_IDCODE;
          r_bsr_oe <= 1'b0;
        end
        TAP_CAP_IR:   r_ir_sh <= c_IR_CAPTURE;
        TAP_SHIFT_IR: r_ir_sh <= {TDI, r_ir_sh[IR_W-1:1]};
        TAP_UPD_IR: begin
          r_ir_q   <= r_ir_sh;
          r_bsr_oe <= (r_ir_sh == c_IR_EXTEST);
        end
        TAP_CAP_DR: begin
          case (w_dr_sel)
            DR_BSR:  r_bsr_sh  <= bsr_pin_in;
            DR_SCAN: r_scan_sh <= scan_cap;
            DR_ID:   r_id_sh   <= IDCODE_VAL;
            default: r_byp     <= 1'b0;
          endcase
        end
        TAP_SHIFT_DR: begin
          case (w_dr_sel)
            DR_BSR:  r_bsr_sh  <= {TDI, r_bsr_sh[BSR_LEN-1:1]};
            DR_SCAN: r_scan_sh <= {TDI, r_scan_sh[SCAN_LEN-1:1]};
            DR_ID:   r_id_sh   <= {TDI, r_id_sh[31:1]};
            default: r_byp     <= TDI;
          endcase
        end
        TAP_UPD_DR: begin
          if (w_dr_sel == DR_BSR)  r_bsr_upd  <= r_bsr_sh;
          if (w_dr_sel == DR_SCAN) r_scan_upd <= r_scan_sh;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tdo = 1'b0;
    if (w_state == TAP_SHIFT_IR) begin
      w_tdo = r_ir_sh[0];
    end else if (w_state == TAP_SHIFT_DR) begin
      case (w_dr_sel)
        DR_BSR:  w_tdo = r_bsr_sh[0];
        DR_SCAN: w_tdo = r_scan_sh[0];
        DR_ID:   w_tdo = r_id_sh[0];
        default: w_tdo = r_byp;
      endcase
    end
  end

  assign TDO         = w_tdo;
  assign bsr_pin_out = r_bsr_upd;
  assign bsr_oe      = r_bsr_oe;
  assign scan_upd    = r_scan_upd;
  assign tap_state   = w_state;
  assign ir_q        = r_ir_q;

endmodule : jtag_tap_param
`default_nettype wire

// File: tb/tb_jtag_tap_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jtag_tap_param : directed vector bench for jtag_tap_param         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jtag_tap_param;

  localparam int          IR_W     = 3;
  localparam int          BSR_LEN  = 150;
  localparam int          SCAN_LEN = 43;
  localparam logic [31:0] ID_VAL   = 32'h1000_0001;

  logic                clk = 1'b0;
  logic                TRST, TMS, TDI, TDO;
  logic [BSR_LEN-1:0]  bsr_pin_in, bsr_pin_out;
  logic                bsr_oe;
  logic [SCAN_LEN-1:0] scan_cap, scan_upd;
  logic [3:0]          tap_state;
  logic [IR_W-1:0]     ir_q;

  jtag_tap_param #(
    .IR_W       (IR_W),
    .BSR_LEN    (BSR_LEN),
    .SCAN_LEN   (SCAN_LEN),
    .IDCODE_VAL (ID_VAL)
  ) dut (
    .clk         (clk),
    .TRST        (TRST),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .bsr_pin_in  (bsr_pin_in),
    .bsr_pin_out (bsr_pin_out),
    .bsr_oe      (bsr_oe),
    .scan_cap    (scan_cap),
    .scan_upd    (scan_upd),
    .tap_state   (tap_state),
    .ir_q        (ir_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
    logic [2:0] irq;
  } vec_t;

  vec_t         tbl [26];
  int           n_vec = 0;
  int           n_err = 0;
  logic [255:0] got;
  logic [255:0] pat;
  logic [255:0] pin_pat;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic tms_v, input logic tdi_v);
    @(negedge clk);
    TMS = tms_v;
    TDI = tdi_v;
    @(posedge clk);
    #1;
  endtask

  // From Run-Test/Idle: load an instruction, return to Run-Test/Idle.
  task automatic load_ir(input logic [IR_W-1:0] v);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("capir_bit0", TDO, 1);
    for (int i = 0; i < IR_W; i++) begin
      step(i == IR_W - 1, v[i]);
      if (i == 0) chk("capir_bit1", TDO, 0);
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("ir_q_loaded", ir_q, v);
  endtask

  task automatic goto_shift_dr();
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic finish_dr();
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  // Shift n bits from Shift-DR, collecting TDO; leaves the FSM in Exit1-DR.
  task automatic shift_dr(input int n, input logic [255:0] din, output logic [255:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      step(i == n - 1, din[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    //             tms   tdi   state  tdo   ir_q
    tbl = '{
      '{1'b1, 1'b0, 4'hF, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hC, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hC, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h7, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'h6, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'h2, 1'b1, 3'd3},
      '{1'b0, 1'b0, 4'h2, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h1, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'h3, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h0, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h5, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h7, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h4, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hE, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hA, 1'b1, 3'd3},
      '{1'b1, 1'b1, 4'h9, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hB, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'h8, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hA, 1'b0, 3'd3},
      '{1'b1, 1'b1, 4'h9, 1'b0, 3'd3},
      '{1'b1, 1'b0, 4'hD, 1'b0, 3'd3},
      '{1'b0, 1'b0, 4'hC, 1'b0, 3'd6},
      '{1'b1, 1'b0, 4'h7, 1'b0, 3'd6},
      '{1'b1, 1'b0, 4'h4, 1'b0, 3'd6},
      '{1'b1, 1'b0, 4'hF, 1'b0, 3'd6},
      '{1'b1, 1'b0, 4'hF, 1'b0, 3'd3}
    };

    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
    bsr_pin_in = '0; scan_cap = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", tap_state, 4'hF);
    chk("rst_ir_q", ir_q, 3);
    chk("rst_tdo", TDO, 0);
    chk("rst_bsr_out", bsr_pin_out, 0);
    chk("rst_scan_upd", scan_upd, 0);
    chk("rst_bsr_oe", bsr_oe, 0);
    @(negedge clk);
    TRST = 1'b0;

    // FSM walk through every state
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].tms, tbl[i].tdi);
      chk($sformatf("tbl%0d_state", i), tap_state, tbl[i].st);
      chk($sformatf("tbl%0d_tdo", i), TDO, tbl[i].tdo);
      chk($sformatf("tbl%0d_ir_q", i), ir_q, tbl[i].irq);
    end

    // IDCODE readout straight out of reset
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("id_in_shift", tap_state, 4'h2);
    shift_dr(32, '0, got);
    chk("idcode_stream", got, ID_VAL);
    finish_dr();
    chk("id_no_bsr_upd", bsr_pin_out, 0);
    chk("id_no_scan_upd", scan_upd, 0);

    // Bypass: all-ones and an unassigned opcode
    for (int k = 0; k < 2; k++) begin
      logic [IR_W-1:0] op;
      op = (k == 0) ? 3'b111 : 3'b101;
      load_ir(op);
      goto_shift_dr();
      shift_dr(4, 256'b1101, got);
      chk($sformatf("bypass_op%0d", op), got, 256'b1010);
      finish_dr();
    end

    // EXTEST: capture pins, shift alternating pattern, update
    pat = '0; pin_pat = '0;
    for (int i = 0; i < BSR_LEN; i++) begin
      pat[i]     = i[0];
      pin_pat[i] = (i % 3 == 0);
    end
    bsr_pin_in = pin_pat[BSR_LEN-1:0];
    load_ir(3'd0);
    chk("extest_oe", bsr_oe, 1);
    goto_shift_dr();
    shift_dr(BSR_LEN, pat, got);
    chk("bsr_capture", got, pin_pat);
    chk("bsr_hold_pre_upd", bsr_pin_out, 0);
    finish_dr();
    chk("bsr_update", bsr_pin_out, pat);
    chk("extest_oe_after", bsr_oe, 1);

    // TRST mid Shift-DR overrides TMS and aborts the shift
    goto_shift_dr();
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    @(negedge clk);
    TRST = 1'b1; TMS = 1'b0;
    @(posedge clk);
    #1;
    chk("trst_state", tap_state, 4'hF);
    chk("trst_ir_q", ir_q, 3);
    chk("trst_tdo", TDO, 0);
    chk("trst_bsr_out", bsr_pin_out, 0);
    chk("trst_bsr_oe", bsr_oe, 0);
    @(negedge clk);
    TRST = 1'b0;
    step(1'b0, 1'b0);
    chk("post_trst_rti", tap_state, 4'hC);

    // INTSCAN: capture, update with ones, then with zeros
    scan_cap = 43'h5CCCC;
    load_ir(3'd2);
    chk("intscan_oe", bsr_oe, 0);
    goto_shift_dr();
    shift_dr(SCAN_LEN, '1, got);
    chk("scan_capture1", got, 256'h5CCCC);
    finish_dr();
    chk("scan_upd_ones", scan_upd, {SCAN_LEN{1'b1}});
    goto_shift_dr();
    shift_dr(SCAN_LEN, '0, got);
    chk("scan_capture2", got, 256'h5CCCC);
    finish_dr();
    chk("scan_upd_zero", scan_upd, 0);
    chk("scan_bsr_hold", bsr_pin_out, 0);

    // Pause-DR then resume without recapture
    load_ir(3'd3);
    goto_shift_dr();
    got = '0;
    for (int i = 0; i < 5; i++) begin
      got[i] = TDO;
      step(i == 4, 1'b0);
    end
    step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk("pause_dr_state", tap_state, 4'h3);
    chk("pause_dr_tdo", TDO, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("resume_shift", tap_state, 4'h2);
    for (int i = 5; i < 32; i++) begin
      got[i] = TDO;
      step(i == 31, 1'b0);
    end
    chk("pause_resume_id", got, ID_VAL);

    // Into Pause-IR with EXTEST in the shifter, then five TMS=1
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("pause_ir_state", tap_state, 4'hB);
    repeat (5) step(1'b1, 1'b0);
    chk("five_tms_tlr", tap_state, 4'hF);
    chk("upd_ir_on_way", ir_q, 0);
    chk("upd_ir_oe", bsr_oe, 1);
    step(1'b1, 1'b0);
    chk("tlr_forces_id", ir_q, 3);
    chk("tlr_clears_oe", bsr_oe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_jtag_tap_param
`default_nettype wire

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 3, instruction register width; minimum 3.
REQ-002 Parameter BSR_LEN, default 150, boundary-scan register length.
REQ-003 Parameter SCAN_LEN, default 43, internal scan chain length.
REQ-004 Parameter IDCODE_VAL, default 32'h1000_0001, device ID; bit 0 SHALL be 1.
REQ-005 clk  input  1  TCK-domain clock; all state changes on its rising edge.
REQ-006 TRST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 TMS  input  1  test mode select.
REQ-008 TDI  input  1  test data in.
REQ-009 TDO  output  1  test data out.
REQ-010 bsr_pin_in  input  BSR_LEN  pin values captured by SAMPLE/EXTEST.
REQ-011 bsr_pin_out  output  BSR_LEN  boundary update latch, drives pins.
REQ-012 bsr_oe  output  1  high while the active instruction is EXTEST.
REQ-013 scan_cap  input  SCAN_LEN  internal state captured by INTSCAN.
REQ-014 scan_upd  output  SCAN_LEN  internal scan update latch.
REQ-015 tap_state  output  4  current TAP state encoding.
REQ-016 ir_q  output  IR_W  active (updated) instruction.

Function
REQ-017 The block SHALL implement the 16-state IEEE 1149.1 TAP FSM (Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR), advanced by TMS on each rising clk edge.
REQ-018 Five consecutive TMS=1 cycles SHALL reach Test-Logic-Reset from any state.
REQ-019 Actions SHALL occur on the rising edge while the FSM is in the named state: Capture loads, Shift shifts, Update latches.
REQ-020 Opcodes: EXTEST=0, SAMPLE=1, INTSCAN=2, IDCODE=3, BYPASS=all-ones; any other code SHALL behave as BYPASS.
REQ-021 DR selection by ir_q: EXTEST/SAMPLE -> BSR (BSR_LEN), INTSCAN -> scan chain (SCAN_LEN), IDCODE -> 32-bit ID, BYPASS -> 1-bit bypass.
REQ-022 Shift SHALL be LSB-first: TDI enters the MSB, register shifts right, TDO = bit 0 of the selected register.
REQ-023 TDO SHALL equal bit 0 of the IR shift register in Shift-IR, of the selected DR in Shift-DR, and 0 in all other states (combinational from registered state).
REQ-024 Capture-IR SHALL load the IR shifter with 0...01 (two LSBs = 01).
REQ-025 Update-IR SHALL copy the IR shifter to ir_q; ir_q SHALL not change elsewhere except in Test-Logic-Reset.
REQ-026 Capture-DR SHALL load: BSR <- bsr_pin_in; scan <- scan_cap; ID <- IDCODE_VAL; bypass <- 0.
REQ-027 Update-DR SHALL copy the BSR shifter to bsr_pin_out (EXTEST/SAMPLE) or the scan shifter to scan_upd (INTSCAN); IDCODE/BYPASS update nothing.
REQ-028 Pause states SHALL hold all shifters; Exit2 -> Shift SHALL resume without recapture.
REQ-029 While in Test-Logic-Reset, ir_q SHALL be IDCODE; latches SHALL hold.
REQ-030 bsr_oe SHALL equal (ir_q == EXTEST), registered with ir_q.

Reset
REQ-031 TRST=1 at a rising edge SHALL set: state Test-Logic-Reset, ir_q=IDCODE, all shifters 0, bsr_pin_out=0, scan_upd=0, bsr_oe=0, TDO=0.
REQ-032 TRST SHALL override TMS and abort any in-progress shift with no Update.

Structure
REQ-033 A shared package jtag_pkg SHALL hold the TAP state enum/encodings and opcode constants.
REQ-034 The FSM SHALL be a sub-module jtag_tap_fsm (clk, TRST, TMS -> state); data registers stay in jtag_tap_param.

Verification
REQ-035 TRST pulse from Shift-DR -> tap_state=Test-Logic-Reset, ir_q=3, TDO=0, bsr_pin_out=0.
REQ-036 After reset, TMS 0,1,0,0 then 32 Shift-DR cycles -> TDO serially emits 32'h1000_0001 LSB first.
REQ-037 Load IR=3'b111, Shift-DR with TDI=1,0,1,1 -> TDO=0,1,0,1 (one-cycle bypass delay, leading 0).
REQ-038 Load IR=0, shift 150'h2AAA...A LSB first, Update-DR -> bsr_pin_out=150'h2AAA...A, bsr_oe=1; Capture-IR readout on TDO starts 1,0.
REQ-039 Load IR=2, scan_cap=43'h5CCCC, shift 43 zeros -> TDO emits 43'h5CCCC LSB first; scan_upd=0 after Update-DR.
REQ-040 Shift-DR -> Pause-DR 10 cycles -> Exit2 -> Shift-DR resumes at the next bit; TMS=1 five cycles from Pause-IR -> Test-Logic-Reset.
